// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: 2-entry in-order elastic pipeline register (main + skid).
// The main register drives the outputs. The skid register absorbs one entry
// while main is held, so in_ready is a plain flop output ("skid empty").
// Optional build macro: PIPE_STAGE_PERF_EN adds saturating stall/flush
// performance counters (perf_stall_cnt, perf_flush_cnt).
module pipeline_stage_reg #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc0,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [ILEN-1:0] in_instr,
  input  logic            in_invalid,
  input  logic            flush,
  input  logic            stall,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc0,
  output logic [XLEN-1:0] out_pc4,
  output logic [ILEN-1:0] out_instr,
  output logic            out_invalid
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  // Bubble entries carry the canonical NOP instead of whatever upstream drove.
  function automatic logic [ILEN-1:0] bubble_instr(input logic            inv,
                                                   input logic [ILEN-1:0] instr);
    return inv ? NOP_INSTR : instr;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  // Skid register (p0) and main register (p1).
  logic            vld_p0;
  logic [XLEN-1:0] pc0_p0;
  logic [XLEN-1:0] pc4_p0;
  logic [ILEN-1:0] instr_p0;
  logic            inv_p0;

  logic            vld_p1;
  logic [XLEN-1:0] pc0_p1;
  logic [XLEN-1:0] pc4_p1;
  logic [ILEN-1:0] instr_p1;
  logic            inv_p1;

  logic            in_xfer;
  logic            drain;
  logic            load_main_in;
  logic            load_main_skid;
  logic            load_skid;
  logic [ILEN-1:0] in_instr_eff;

  // Skid is only ever occupied while main is occupied, so "skid empty" is the
  // whole acceptance condition and needs no combinational path from downstream.
  assign in_ready       = ~vld_p0;
  assign in_xfer        = in_valid & in_ready;
  assign drain          = vld_p1 & out_ready & ~stall;
  assign in_instr_eff   = bubble_instr(in_invalid, in_instr);

  // Flush blocks every data move; reset is handled separately below.
  assign load_main_skid = ~flush & drain & vld_p0;
  assign load_main_in   = ~flush & in_xfer & (~vld_p1 | drain);
  assign load_skid      = ~flush & in_xfer & vld_p1 & ~drain;

  // Occupancy control: reset, then flush, then drain/fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (drain) begin
      if (vld_p0) begin
        vld_p0 <= 1'b0;
      end else begin
        vld_p1 <= in_xfer;
      end
    end else if (!vld_p1) begin
      vld_p1 <= in_xfer;
    end else if (in_xfer) begin
      vld_p0 <= 1'b1;
    end
  end

  // ---- stage p1: main register, loaded from skid first, else from input ----
  // PCs are left untouched when main empties so they hold their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc0_p1   <= '0;
      pc4_p1   <= '0;
      instr_p1 <= NOP_INSTR;
      inv_p1   <= 1'b1;
    end else if (load_main_skid) begin
      pc0_p1   <= pc0_p0;
      pc4_p1   <= pc4_p0;
      instr_p1 <= instr_p0;
      inv_p1   <= inv_p0;
    end else if (load_main_in) begin
      pc0_p1   <= in_pc0;
      pc4_p1   <= in_pc4;
      instr_p1 <= in_instr_eff;
      inv_p1   <= in_invalid;
    end
  end

  // ---- stage p0: skid register, captures input while main is held ----
  always_ff @(posedge clk) begin
    if (load_skid) begin
      pc0_p0   <= in_pc0;
      pc4_p0   <= in_pc4;
      instr_p0 <= in_instr_eff;
      inv_p0   <= in_invalid;
    end
  end

  assign out_valid   = vld_p1;
  assign out_pc0     = pc0_p1;
  assign out_pc4     = pc4_p1;
  assign out_instr   = vld_p1 ? instr_p1 : NOP_INSTR;
  assign out_invalid = vld_p1 ? inv_p1 : 1'b1;

`ifdef PIPE_STAGE_PERF_EN
  // Saturating counters: cycles holding a valid output, and flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (vld_p1 && !(out_ready && !stall)) begin
        perf_stall_cnt <= sat_inc(perf_stall_cnt);
      end
      if (flush) begin
        perf_flush_cnt <= sat_inc(perf_flush_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// tb_pipeline_stage_reg: directed scenarios plus randomized traffic, checked
// every cycle against a depth-2 FIFO reference model of the stage.
module tb_pipeline_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc0 = '0;
  logic [31:0] in_pc4 = '0;
  logic [31:0] in_instr = '0;
  logic        in_invalid = 1'b0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc0;
  logic [31:0] out_pc4;
  logic [31:0] out_instr;
  logic        out_invalid;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  pipeline_stage_reg dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc0     (in_pc0),
    .in_pc4     (in_pc4),
    .in_instr   (in_instr),
    .in_invalid (in_invalid),
    .flush      (flush),
    .stall      (stall),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc0    (out_pc0),
    .out_pc4    (out_pc4),
    .out_instr  (out_instr),
    .out_invalid(out_invalid)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: in-order queue of at most 2 ----------------
  typedef struct packed {
    logic [31:0] pc0;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        inv;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc0 = '0;
  logic [31:0] m_pc4 = '0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
  bit          mdl_on = 1'b0;

  function automatic logic [31:0] sat32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always @(posedge clk) begin : model
    ent_t e;
    bit   do_pop;
    bit   do_push;
    if (rst) begin
      q.delete();
      m_pc0   = '0;
      m_pc4   = '0;
      m_stall = '0;
      m_flush = '0;
      mdl_on  = 1'b1;
    end else begin
      if (q.size() != 0 && !(out_ready && !stall)) m_stall = sat32(m_stall);
      if (flush) m_flush = sat32(m_flush);
      if (flush) begin
        q.delete();
      end else begin
        do_pop  = (q.size() != 0) && out_ready && !stall;
        do_push = in_valid && (q.size() < 2);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          e.pc0   = in_pc0;
          e.pc4   = in_pc4;
          e.instr = in_invalid ? 32'h0000_0013 : in_instr;
          e.inv   = in_invalid;
          q.push_back(e);
        end
      end
    end
    if (q.size() != 0) begin
      m_pc0 = q[0].pc0;
      m_pc4 = q[0].pc4;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin : compare
    logic [31:0] e_instr;
    logic        e_inv;
    if (mdl_on) begin
      if (q.size() != 0) begin
        e_instr = q[0].instr;
        e_inv   = q[0].inv;
      end else begin
        e_instr = 32'h0000_0013;
        e_inv   = 1'b1;
      end
      chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("m_out_pc0", out_pc0, m_pc0);
      chk("m_out_pc4", out_pc4, m_pc4);
      chk("m_out_instr", out_instr, e_instr);
      chk("m_out_invalid", 32'(out_invalid), 32'(e_inv));
`ifdef PIPE_STAGE_PERF_EN
      chk("m_perf_stall", perf_stall_cnt, m_stall);
      chk("m_perf_flush", perf_flush_cnt, m_flush);
`endif
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic inv);
    in_valid   = v;
    in_pc0     = pc;
    in_pc4     = pc + 32'd4;
    in_instr   = ins;
    in_invalid = inv;
  endtask

  initial begin
    // Reset, then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_instr", out_instr, 32'h0000_0013);
    chk("idle_invalid", 32'(out_invalid), 32'd1);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_pc0", out_pc0, 32'd0);

    // Streaming with out_ready=1: one-cycle latency, in order
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0);
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_pc0", out_pc0, 32'h100 + 32'(4 * i));
      chk("stream_pc4", out_pc4, 32'h104 + 32'(4 * i));
      chk("stream_instr", out_instr, 32'h1000 + 32'(i));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("stream_end_valid", 32'(out_valid), 32'd0);
    chk("stream_end_pc0_hold", out_pc0, 32'h108);

    // Backpressure: two accepted, third waits until drain
    out_ready = 1'b0;
    drive(1'b1, 32'h300, 32'hA, 1'b0);
    tick();
    chk("bp_ready_1", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h304, 32'hB, 1'b0);
    tick();
    chk("bp_ready_2", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h308, 32'hC, 1'b0);
    tick();
    chk("bp_hold_pc0", out_pc0, 32'h300);
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_drain1_pc0", out_pc0, 32'h304);
    chk("bp_drain1_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_drain2_pc0", out_pc0, 32'h308);
    chk("bp_drain2_instr", out_instr, 32'hC);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Stall with skid full, then flush with stall still high
    stall = 1'b1;
    drive(1'b1, 32'h400, 32'hD, 1'b0);
    tick();
    chk("st_main_pc0", out_pc0, 32'h400);
    drive(1'b1, 32'h404, 32'hE, 1'b0);
    tick();
    chk("st_skid_full", 32'(in_ready), 32'd0);
    chk("st_frozen_pc0", out_pc0, 32'h400);
    flush = 1'b1;
    drive(1'b1, 32'h408, 32'hF, 1'b0);
    tick();
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    chk("fl_instr", out_instr, 32'h0000_0013);
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("fl_stays_empty", 32'(out_valid), 32'd0);

    // Bubble entry keeps PCs, replaces instruction
    drive(1'b1, 32'h200, 32'hDEAD_BEEF, 1'b1);
    tick();
    chk("bub_valid", 32'(out_valid), 32'd1);
    chk("bub_instr", out_instr, 32'h0000_0013);
    chk("bub_invalid", 32'(out_invalid), 32'd1);
    chk("bub_pc0", out_pc0, 32'h200);
    chk("bub_pc4", out_pc4, 32'h204);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();

`ifdef PIPE_STAGE_PERF_EN
    // Performance counters: 5 stalled valid cycles, 2 flushes, then reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("perf_rst_stall", perf_stall_cnt, 32'd0);
    chk("perf_rst_flush", perf_flush_cnt, 32'd0);
    out_ready = 1'b1;
    stall = 1'b1;
    drive(1'b1, 32'h500, 32'h5, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (5) tick();
    stall = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("perf_stall_5", perf_stall_cnt, 32'd5);
    chk("perf_flush_2", perf_flush_cnt, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("perf_clr_stall", perf_stall_cnt, 32'd0);
    chk("perf_clr_flush", perf_flush_cnt, 32'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc         = $urandom() & 32'hFFFF_FFFC;
      rst        = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      stall      = ($urandom_range(0, 4) == 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      drive(($urandom_range(0, 3) != 0), pc, $urandom(), ($urandom_range(0, 7) == 0));
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset (`clk`, `rst`); every state element SHALL update only on the rising edge of `clk`.
REQ-002 Parameter XLEN, default 32: PC field width in bits.
REQ-003 Parameter ILEN, default 32: instruction field width in bits.
REQ-004 Parameter NOP_INSTR, default 32'h0000_0013: bubble instruction encoding (ADDI x0,x0,0).
REQ-005 Ports, in order (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- in_valid, in, 1: upstream entry present.
- in_ready, out, 1: stage can accept an entry.
- in_pc0, in, XLEN: PC of the instruction.
- in_pc4, in, XLEN: PC+4.
- in_instr, in, ILEN: instruction word.
- in_invalid, in, 1: entry is a bubble.
- flush, in, 1: discard all held entries.
- stall, in, 1: hold the output entry.
- out_valid, out, 1: output entry present.
- out_ready, in, 1: downstream can accept.
- out_pc0, out, XLEN: PC field.
- out_pc4, out, XLEN: PC+4 field.
- out_instr, out, ILEN: instruction field.
- out_invalid, out, 1: output is a bubble.

Function
REQ-006 Storage SHALL be a 2-entry in-order elastic buffer: a main register driving the outputs, plus a skid register.
REQ-007 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready && !stall.
REQ-008 in_ready SHALL be a registered signal equal to "skid empty"; it SHALL NOT depend combinationally on out_ready or stall.
REQ-009 Latency SHALL be 1 cycle: an entry accepted in cycle N appears on the outputs in cycle N+1 if, in cycle N, main is empty or is draining and skid is empty.
REQ-010 An entry accepted while main is occupied and not draining SHALL go to skid.
REQ-011 When main drains while skid is full, skid SHALL move to main and skid SHALL become empty; no input transfer is possible in that cycle (in_ready=0).
REQ-012 When main drains, skid is empty and an input transfer occurs in the same cycle, the new entry SHALL load main directly.
REQ-013 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush.
REQ-014 An entry accepted with in_invalid=1 SHALL be stored with instruction NOP_INSTR and invalid=1, with its PCs preserved.
REQ-015 When out_valid=0, the outputs SHALL show out_instr=NOP_INSTR and out_invalid=1; out_pc0 and out_pc4 SHALL hold their last values.
REQ-016 stall=1 SHALL freeze main. Upstream MAY still fill skid while stalled.
REQ-017 flush=1 SHALL empty both entries on the next edge (out_valid=0, in_ready=1).
REQ-018 An input transfer in a flush cycle SHALL be discarded. Flush SHALL take priority over stall and drain.
REQ-019 All arithmetic SHALL be width-exact; no field truncation or extension inside the block.

Reset
REQ-020 On rst=1, on the next edge: out_valid=0, in_ready=1, out_pc0=0, out_pc4=0, out_instr=NOP_INSTR, out_invalid=1, skid empty.
REQ-021 Reset SHALL take priority over flush, stall and any transfer; entries in flight at reset SHALL be lost.

Configuration
REQ-022 With macro PIPE_STAGE_PERF_EN defined, the block SHALL add the output ports:
- perf_stall_cnt, 32 bits: counts cycles with out_valid && !(out_ready && !stall).
- perf_flush_cnt, 32 bits: counts cycles with flush=1.
REQ-023 Both counters SHALL saturate at 32'hFFFF_FFFF and SHALL reset to 0.
REQ-024 Without PIPE_STAGE_PERF_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Reset, then idle: out_valid=0, out_instr=32'h13, out_invalid=1, in_ready=1.
- Stream pc0=0x100,0x104,0x108 with out_ready=1: each appears 1 cycle after acceptance, in order, out_pc4=pc0+4.
- Hold out_ready=0 and push 3 entries: 2 accepted, in_ready=0 after the second; on release, they drain in order and the third is then accepted.
- stall=1 with skid full plus flush=1 in the same cycle: next cycle out_valid=0, in_ready=1, out_instr=32'h13.
- in_invalid=1 with in_instr=0xDEADBEEF, pc0=0x200: output shows instr=32'h13, invalid=1, pc0=0x200.
- With PIPE_STAGE_PERF_EN: 5 stalled valid cycles and 2 flushes give perf_stall_cnt=5 and perf_flush_cnt=2; rst returns both to 0.
